// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability qualifier FSM, registered level/strobe
// outputs and a saturating count of aborted qualifications (bounce episodes).
module key_debounce #(
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned CNT_WIDTH     = 20,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned BOUNCE_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_in,
   output logic                key_out,
   output logic                pressed,
   output logic                press_pulse,
   output logic                release_pulse,
   output logic [BOUNCE_W-1:0] bounce_cnt
);

   localparam logic                 REL_LEVEL  = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [BOUNCE_W-1:0]  BOUNCE_MAX = '1;

   typedef enum logic [1:0] {
      StReleased,
      StWaitPress,
      StPressed,
      StWaitRelease
   } state_t;

   state_t               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 sync_meta_q;
   logic                 s_q;
   logic                 p_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta_q   <= REL_LEVEL;
         s_q           <= REL_LEVEL;
         p_q           <= 1'b0;
         state_q       <= StReleased;
         cnt_q         <= '0;
         key_out       <= REL_LEVEL;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         bounce_cnt    <= '0;
      end else begin
         sync_meta_q   <= key_in;
         s_q           <= sync_meta_q;
         // Registered "pressed-level" sample decouples the FSM from the synchroniser output.
         p_q           <= (s_q != REL_LEVEL);
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;

         unique case (state_q)
            StReleased: begin
               if (p_q) begin
                  state_q <= StWaitPress;
                  cnt_q   <= '0;
               end
            end
            StWaitPress: begin
               if (!p_q) begin
                  state_q <= StReleased;
                  cnt_q   <= '0;
                  if (bounce_cnt != BOUNCE_MAX) bounce_cnt <= bounce_cnt + BOUNCE_W'(1);
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= StPressed;
                  cnt_q       <= '0;
                  press_pulse <= 1'b1;
                  pressed     <= 1'b1;
                  key_out     <= ~REL_LEVEL;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            StPressed: begin
               if (!p_q) begin
                  state_q <= StWaitRelease;
                  cnt_q   <= '0;
               end
            end
            StWaitRelease: begin
               if (p_q) begin
                  state_q <= StPressed;
                  cnt_q   <= '0;
                  if (bounce_cnt != BOUNCE_MAX) bounce_cnt <= bounce_cnt + BOUNCE_W'(1);
               end else if (cnt_q == CNT_LAST) begin
                  state_q       <= StReleased;
                  cnt_q         <= '0;
                  release_pulse <= 1'b1;
                  pressed       <= 1'b0;
                  key_out       <= REL_LEVEL;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_q <= StReleased;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: tasks push expected pulses (kind, edge, bounce count) to a queue;
// a negedge monitor pops and compares each pulse the DUT emits.
module tb_key_debounce;

   localparam int unsigned STABLE = 4;
   // Key driven at a negedge after edge k; pulse is visible at the negedge after edge k+STABLE+4.
   localparam int unsigned LAT    = STABLE + 4;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       key_in = 1'b1;
   logic       key_out;
   logic       pressed;
   logic       press_pulse;
   logic       release_pulse;
   logic [7:0] bounce_cnt;

   typedef struct {
      bit         is_rel;
      int         edge_no;
      logic [7:0] bcnt;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   bit         mon_p;
   int         edge_n     = 0;
   int         n_checks   = 0;
   int         n_fail     = 0;
   logic [7:0] exp_bounce = 8'd0;

   key_debounce #(
      .STABLE_CYCLES(STABLE),
      .CNT_WIDTH    (3),
      .ACTIVE_LOW   (1'b1),
      .BOUNCE_W     (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in),
      .key_out      (key_out),
      .pressed      (pressed),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .bounce_cnt   (bounce_cnt)
   );

   always #10 clk = ~clk;
   always @(posedge clk) edge_n++;

   // Scoreboard consumer: every pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: edge %0d press_pulse=%b release_pulse=%b, required none",
                     edge_n, press_pulse, release_pulse);
         end else begin
            mon_e = exp_q.pop_front();
            mon_p = ~mon_e.is_rel;
            if (press_pulse !== mon_p || release_pulse !== mon_e.is_rel ||
                edge_n != mon_e.edge_no || pressed !== mon_p || key_out !== mon_e.is_rel ||
                bounce_cnt !== mon_e.bcnt) begin
               n_fail++;
               $display({"FAIL pulse_check: got press=%b rel=%b edge=%0d pressed=%b key_out=%b ",
                         "bounce=%0d, required press=%b rel=%b edge=%0d pressed=%b key_out=%b ",
                         "bounce=%0d"},
                        press_pulse, release_pulse, edge_n, pressed, key_out, bounce_cnt,
                        mon_p, mon_e.is_rel, mon_e.edge_no, mon_p, mon_e.is_rel, mon_e.bcnt);
            end
         end
      end
   end

   task automatic wait_until(input int target);
      while (edge_n < target) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      key_in = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({key_out, pressed, press_pulse, release_pulse, bounce_cnt} !== {4'b1000, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got key_out=%b pressed=%b pp=%b rp=%b bounce=%0d, required 1 0 0 0 0",
                  key_out, pressed, press_pulse, release_pulse, bounce_cnt);
      end
      key_in = 1'b1;
      rst_n  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if ({key_out, pressed, bounce_cnt} !== {2'b10, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_idle: cycle %0d got key_out=%b pressed=%b bounce=%0d, required 1 0 0",
                     i, key_out, pressed, bounce_cnt);
         end
      end
   endtask

   task automatic test_clean_press();
      int k;
      k      = edge_n;
      key_in = 1'b0;
      exp_q.push_back('{1'b0, k + LAT, exp_bounce});
      wait_until(k + LAT - 1);
      n_checks++;
      if ({key_out, pressed} !== 2'b10) begin
         n_fail++;
         $display("FAIL press_early: got key_out=%b pressed=%b, required 1 0", key_out, pressed);
      end
      @(negedge clk);
      n_checks++;
      if ({key_out, pressed} !== 2'b01) begin
         n_fail++;
         $display("FAIL press_level: got key_out=%b pressed=%b, required 0 1", key_out, pressed);
      end
      @(negedge clk);
      n_checks++;
      if ({press_pulse, key_out, pressed} !== 3'b001) begin
         n_fail++;
         $display("FAIL press_width: got pp=%b key_out=%b pressed=%b, required 0 0 1",
                  press_pulse, key_out, pressed);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL press_missing: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_clean_release();
      int k;
      k      = edge_n;
      key_in = 1'b1;
      exp_q.push_back('{1'b1, k + LAT, exp_bounce});
      wait_until(k + LAT - 1);
      n_checks++;
      if ({key_out, pressed} !== 2'b01) begin
         n_fail++;
         $display("FAIL release_early: got key_out=%b pressed=%b, required 0 1", key_out, pressed);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0 || {key_out, pressed} !== 2'b10) begin
         n_fail++;
         $display("FAIL release_done: got pending=%0d key_out=%b pressed=%b, required 0 1 0",
                  exp_q.size(), key_out, pressed);
         exp_q.delete();
      end
   endtask

   task automatic test_bounce();
      int k;
      for (int i = 0; i < 2; i++) begin
         key_in = 1'b0;
         repeat (2) @(negedge clk);
         key_in = 1'b1;
         repeat (2) @(negedge clk);
      end
      k          = edge_n;
      key_in     = 1'b0;
      exp_bounce = exp_bounce + 8'd2;
      exp_q.push_back('{1'b0, k + LAT, exp_bounce});
      wait_until(k + LAT - 1);
      n_checks++;
      if ({key_out, bounce_cnt} !== {1'b1, exp_bounce}) begin
         n_fail++;
         $display("FAIL bounce_pre: got key_out=%b bounce=%0d, required 1 %0d",
                  key_out, bounce_cnt, exp_bounce);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0 || key_out !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_post: got pending=%0d key_out=%b, required 0 0", exp_q.size(), key_out);
         exp_q.delete();
      end
   endtask

   task automatic test_release_bounce();
      key_in = 1'b1;
      repeat (3) @(negedge clk);
      key_in     = 1'b0;
      exp_bounce = exp_bounce + 8'd1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         n_checks++;
         if ({key_out, pressed} !== 2'b01) begin
            n_fail++;
            $display("FAIL rel_bounce_level: cycle %0d got key_out=%b pressed=%b, required 0 1",
                     i, key_out, pressed);
         end
      end
      n_checks++;
      if (bounce_cnt !== exp_bounce) begin
         n_fail++;
         $display("FAIL rel_bounce_cnt: got %0d, required %0d", bounce_cnt, exp_bounce);
      end
      test_clean_release();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         key_in = 1'b0;
         @(negedge clk);
         key_in = 1'b1;
         repeat (2) @(negedge clk);
         if (exp_bounce != 8'hFF) exp_bounce = exp_bounce + 8'd1;
         if (i == 99) begin
            repeat (6) @(negedge clk);
            n_checks++;
            if (bounce_cnt !== exp_bounce) begin
               n_fail++;
               $display("FAIL sat_mid: got %0d, required %0d", bounce_cnt, exp_bounce);
            end
         end
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (bounce_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_top: got %0d, required 255", bounce_cnt);
      end
      key_in = 1'b0;
      @(negedge clk);
      key_in = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (bounce_cnt !== 8'd255 || key_out !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_hold: got bounce=%0d key_out=%b, required 255 1", bounce_cnt, key_out);
      end
   endtask

   task automatic test_mid_reset();
      int k;
      k      = edge_n;
      key_in = 1'b0;
      wait_until(k + 6);
      n_checks++;
      if (dut.cnt_q !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_reset_cnt: got %0d, required 2", dut.cnt_q);
      end
      rst_n  = 1'b0;
      key_in = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({key_out, pressed, press_pulse, release_pulse, bounce_cnt} !== {4'b1000, 8'd0}) begin
         n_fail++;
         $display("FAIL mid_reset_state: got key_out=%b pressed=%b pp=%b rp=%b bounce=%0d, required 1 0 0 0 0",
                  key_out, pressed, press_pulse, release_pulse, bounce_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if ({key_out, pressed, bounce_cnt} !== {2'b10, 8'd0} || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset_after: got key_out=%b pressed=%b bounce=%0d pending=%0d, required 1 0 0 0",
                  key_out, pressed, bounce_cnt, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_clean_release();
      repeat (4) @(negedge clk);
      test_bounce();
      repeat (4) @(negedge clk);
      test_release_bounce();
      repeat (4) @(negedge clk);
      test_saturation();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw push-button (DE2i-150 KEY[n], active-low, asynchronous, bouncy) into a clean, CLOCK_50-synchronous level.
- Sits directly upstream of edge_detect.
- key_out feeds edge_detect.trigger in place of the raw KEY line. press_pulse/release_pulse drive the counter logic directly where no separate edge stage is wanted.
- Also counts rejected bounce episodes so the top level can display contact quality on LEDR.

Parameters:
- STABLE_CYCLES, 1000000, consecutive cycles the synchronised input must hold a new level before it is accepted (20 ms at 50 MHz). Legal range 2 to 2^CNT_WIDTH.
- CNT_WIDTH, 20, width of the qualification counter. Must hold STABLE_CYCLES-1.
- ACTIVE_LOW, 1, 1: pressed = key_in low (DE2i-150 KEY). 0: pressed = key_in high.
- BOUNCE_W, 8, width of the bounce statistics counter.

Ports:
- clk  input  1  system clock (CLOCK_50)
- rst_n  input  1  reset; synchronous, active-low
- key_in  input  1  raw asynchronous button level
- key_out  output  1  debounced level, same polarity as key_in
- pressed  output  1  debounced level, active-high (1 = held)
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- bounce_cnt  output  BOUNCE_W  saturating count of aborted qualifications

Behaviour:
- Reset, when rst_n = 0 at a clk edge:
  - Both synchroniser flops load the released level (1 if ACTIVE_LOW, else 0).
  - State = RELEASED, counter = 0.
  - key_out = released level, pressed = 0, press_pulse = 0, release_pulse = 0, bounce_cnt = 0.
  - Reset mid-qualification discards the qualification with no pulse and no bounce count.
- Synchroniser: 2-FF chain on key_in. Only the second flop (s) is used downstream. No combinational path from key_in to any output.
- p = (s == pressed level).
- FSM states and transitions:
  - RELEASED: if p, go to WAIT_PRESS with cnt = 0.
  - WAIT_PRESS:
    - If !p: go to RELEASED, cnt = 0, bounce_cnt += 1.
    - Else if cnt == STABLE_CYCLES-1: go to PRESSED, cnt = 0, press_pulse = 1 for this one cycle.
    - Else: cnt += 1.
  - PRESSED: if !p, go to WAIT_RELEASE with cnt = 0.
  - WAIT_RELEASE:
    - If p: go to PRESSED, cnt = 0, bounce_cnt += 1.
    - Else if cnt == STABLE_CYCLES-1: go to RELEASED, cnt = 0, release_pulse = 1 for this one cycle.
    - Else: cnt += 1.
- Outputs:
  - pressed = 1 in PRESSED and WAIT_RELEASE, 0 otherwise.
  - key_out = ACTIVE_LOW ? ~pressed : pressed.
  - All outputs are registered.
- Latency: a clean raw transition sampled first at edge 0 changes key_out/pressed and fires the pulse on edge STABLE_CYCLES+3. The pulse is high for exactly one cycle and coincides with the first cycle of the new level.
- A pulse shorter than STABLE_CYCLES+1 synchronised cycles never changes key_out. Each abort increments bounce_cnt once.
- bounce_cnt saturates at 2^BOUNCE_W-1 and never wraps.
- press_pulse and release_pulse are never high in the same cycle. Consecutive press_pulses are at least 2*STABLE_CYCLES+2 cycles apart.
- cnt never exceeds STABLE_CYCLES-1, and is 0 in RELEASED and PRESSED.

Test Plan (STABLE_CYCLES=4, ACTIVE_LOW=1, BOUNCE_W=8):
- Reset: hold rst_n=0 for 3 cycles with key_in=0 -> key_out=1, pressed=0, both pulses 0, bounce_cnt=0. Release rst_n with key_in=1 held -> no pulse for 20 cycles.
- Clean press: key_in 1->0 before edge 0, then held -> key_out=0, pressed=1, press_pulse=1 exactly at edge 7. Pulse is 0 at edge 8. Clean release gives release_pulse at edge 7 after key_in returns to 1.
- Bounce: key_in low 2 cycles, high 2, low 2, high 2, then low held -> two aborts, bounce_cnt=2, exactly one press_pulse, key_out=0 only after 4 stable synchronised cycles.
- Release bounce: from PRESSED, key_in high 3 cycles then low -> no release_pulse, key_out stays 0, bounce_cnt increments by 1.
- Saturation: 300 aborted 1-cycle glitches -> bounce_cnt stops at 255 and stays there.
- Mid-qualification reset: assert rst_n=0 while in WAIT_PRESS at cnt=2 -> no press_pulse, key_out=1, state RELEASED, bounce_cnt unchanged by the abort.
